// File: rtl/key_poll_ctrl.sv
// Key PIO poller: periodically reads and clears the PIO edge-capture register and queues non-zero key edge sets in a small FIFO.
// Optional feature: define KEY_POLL_CTRL_IRQ_EN to drive irq from evt_valid delayed by one cycle; otherwise irq is tied low.
module key_poll_ctrl #(
    parameter int POLL_DIV   = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    output logic        evt_valid,
    output logic [3:0]  evt_data,
    input  logic        evt_ready,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic        irq
);

    localparam int CW = $clog2(POLL_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(POLL_DIV - 1);
    localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        CLR  = 3'd3,
        PUSH = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic            tick_s;
    logic [3:0]      cap_r;
    logic [1:0]      addr_r, addr_s;
    logic            cs_r, cs_s;
    logic            wn_r, wn_s;
    logic [31:0]     wd_r, wd_s;
    logic [3:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_s;
    logic [NW-1:0]   count_r, count_s;
    logic            full_s, push_s, pop_s, ovf_set_s;
    logic [3:0]      front_s, evt_data_r;
    logic            evt_valid_r, ovf_r;
    logic            unused_s;

    assign unused_s = ^pio_readdata[31:4];
    assign tick_s   = (cnt_r == CNT_MAX);

    // Free-running poll divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Next state plus bus values for the upcoming state, so the bus pins come straight from flops.
    always_comb begin
        state_s = state_r;
        addr_s  = 2'd0;
        cs_s    = 1'b0;
        wn_s    = 1'b1;
        wd_s    = 32'd0;
        case (state_r)
            IDLE: begin
                if (tick_s) state_s = RD;
                else        state_s = IDLE;
            end
            RD:   state_s = CAP;
            CAP: begin
                if (pio_readdata[3:0] != 4'd0) state_s = CLR;
                else                           state_s = IDLE;
            end
            CLR:  state_s = PUSH;
            PUSH: state_s = IDLE;
            default: state_s = IDLE;
        endcase
        case (state_s)
            RD: begin
                cs_s   = 1'b1;
                addr_s = 2'd3;
            end
            CLR: begin
                cs_s   = 1'b1;
                wn_s   = 1'b0;
                addr_s = 2'd3;
            end
            default: begin
                cs_s   = 1'b0;
                wn_s   = 1'b1;
                addr_s = 2'd0;
            end
        endcase
    end

    // FSM state, registered bus outputs and captured edge set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            addr_r  <= 2'd0;
            cs_r    <= 1'b0;
            wn_r    <= 1'b1;
            wd_r    <= 32'd0;
            cap_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            cs_r    <= cs_s;
            wn_r    <= wn_s;
            wd_r    <= wd_s;
            if (state_r == CAP) cap_r <= pio_readdata[3:0];
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    always_comb begin
        full_s    = (count_r == DEPTH_N);
        pop_s     = evt_valid_r && evt_ready;
        push_s    = (state_r == PUSH) && (!full_s || pop_s);
        ovf_set_s = (state_r == PUSH) && full_s && !pop_s;
        rd_ptr_s  = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + NW'(1);
            2'b01:   count_s = count_r - NW'(1);
            default: count_s = count_r;
        endcase
        if (push_s && (wr_ptr_r == rd_ptr_s)) front_s = cap_r;
        else                                  front_s = mem_r[rd_ptr_s];
    end

    // FIFO storage, pointers, registered head-of-queue and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 4'd0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            evt_valid_r <= 1'b0;
            evt_data_r  <= 4'd0;
            ovf_r       <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= cap_r;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            evt_valid_r <= (count_s != '0);
            evt_data_r  <= front_s;
            if (ovf_set_s)    ovf_r <= 1'b1;
            else if (ovf_clr) ovf_r <= 1'b0;
        end
    end

`ifdef KEY_POLL_CTRL_IRQ_EN
    logic irq_r;

    // Interrupt follows evt_valid one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_r <= 1'b0;
        else          irq_r <= evt_valid_r;
    end
    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    assign pio_address    = addr_r;
    assign pio_chipselect = cs_r;
    assign pio_write_n    = wn_r;
    assign pio_writedata  = wd_r;
    assign evt_valid      = evt_valid_r;
    assign evt_data       = evt_data_r;
    assign ovf            = ovf_r;

endmodule

// File: tb/tb_key_poll_ctrl.sv
// Self-checking bench for key_poll_ctrl with a key PIO edge-capture model and an event scoreboard.
module tb_key_poll_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        evt_valid;
    logic [3:0]  evt_data;
    logic        evt_ready;
    logic        ovf;
    logic        ovf_clr;
    logic        irq;

    logic [3:0]  key_pulse;
    logic [3:0]  edge_cap;
    logic [3:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_cnt, clr_cnt, pop_cnt;
    logic        rd_seen, clr_seen, any_valid;

    key_poll_ctrl #(.POLL_DIV(8), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .evt_ready      (evt_ready),
        .ovf            (ovf),
        .ovf_clr        (ovf_clr),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key PIO model: edge-capture register at address 3, registered reads, any write clears it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap     <= 4'd0;
            pio_readdata <= 32'd0;
        end else begin
            if (pio_chipselect && pio_write_n && pio_address == 2'd3)
                pio_readdata <= {28'd0, edge_cap};
            if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
                edge_cap <= 4'd0;
            else
                edge_cap <= edge_cap | key_pulse;
        end
    end

    task automatic sb_pop();
        logic [3:0] e;
        if (evt_valid && evt_ready) begin
            n_vec++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_pop: got evt_data=%h, expected no event", evt_data);
            end else begin
                e = exp_q.pop_front();
                if (evt_data !== e) begin
                    n_err++;
                    $display("FAIL sb_pop: got evt_data=%h, expected %h", evt_data, e);
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        rd_seen  = pio_chipselect && pio_write_n && (pio_address == 2'd3);
        clr_seen = pio_chipselect && !pio_write_n && (pio_address == 2'd3);
        if (rd_seen)   rd_cnt++;
        if (clr_seen)  clr_cnt++;
        if (evt_valid) any_valid = 1'b1;
        sb_pop();
    endtask

    task automatic wait_rd();
        logic found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (rd_seen) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL wait_rd: got no RD cycle in 40 cycles, expected one");
        end
    endtask

    task automatic wait_clr();
        logic found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (clr_seen) begin
                found = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL wait_clr: got no CLR cycle in 40 cycles, expected one");
        end
    endtask

    // Inject edges well clear of the read-to-clear window of any poll.
    task automatic inject(input logic [3:0] val);
        wait_rd();
        repeat (4) cycle();
        key_pulse = val;
        cycle();
        key_pulse = 4'd0;
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        sb_pop();
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle();
        cycle();
        evt_ready = 1'b0;
        n_vec++;
        if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got evt_valid=%b left=%0d, expected 0 and 0", evt_valid, exp_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_vec++;
        if ({pio_chipselect, pio_write_n, pio_address} !== 4'b0100 || pio_writedata !== 32'd0) begin
            n_err++;
            $display("FAIL %s bus: got cs=%b wn=%b addr=%0d wd=%h, expected 0 1 0 0",
                     tag, pio_chipselect, pio_write_n, pio_address, pio_writedata);
        end
        n_vec++;
        if ({evt_valid, ovf, irq} !== 3'b000) begin
            n_err++;
            $display("FAIL %s flags: got valid=%b ovf=%b irq=%b, expected 0 0 0", tag, evt_valid, ovf, irq);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        key_pulse = 4'd0;
        rd_cnt = 0; clr_cnt = 0; pop_cnt = 0; any_valid = 1'b0;
        repeat (3) cycle();
        check_idle_outputs("reset");
        reset_n = 1'b1;
    endtask

    task automatic test_no_activity();
        rd_cnt = 0; clr_cnt = 0; any_valid = 1'b0;
        wait_rd();
        repeat (39) cycle();
        n_vec++;
        if (rd_cnt != 5 || clr_cnt != 0 || any_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_activity: got rd=%0d clr=%0d valid=%b, expected 5 0 0", rd_cnt, clr_cnt, any_valid);
        end
    endtask

    task automatic test_single_key();
        inject(4'h4);
        exp_q.push_back(4'h4);
        rd_cnt = 0; clr_cnt = 0;
        repeat (10) cycle();
        n_vec++;
        if (rd_cnt != 1 || clr_cnt != 1) begin
            n_err++;
            $display("FAIL single_key pair: got rd=%0d clr=%0d, expected 1 1", rd_cnt, clr_cnt);
        end
        n_vec++;
        if (evt_valid !== 1'b1 || evt_data !== 4'h4 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL single_key out: got valid=%b data=%h ovf=%b, expected 1 4 0", evt_valid, evt_data, ovf);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) begin
            inject(4'h1);
            if (k < 4) exp_q.push_back(4'h1);
            repeat (8) cycle();
            if (k == 3) begin
                n_vec++;
                if (ovf !== 1'b0) begin
                    n_err++;
                    $display("FAIL overflow early: got ovf=%b after 4 pushes, expected 0", ovf);
                end
            end
        end
        n_vec++;
        if (ovf !== 1'b1 || evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overflow set: got ovf=%b valid=%b, expected 1 1", ovf, evt_valid);
        end
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        cycle();
        n_vec++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL overflow clr: got ovf=%b, expected 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        inject(4'h8);
        wait_clr();
        cycle();
        evt_ready = 1'b1;
        pop_cnt = 0;
        sb_pop();
        exp_q.push_back(4'h8);
        @(posedge clk);
        #1 evt_ready = 1'b0;
        cycle();
        n_vec++;
        if (ovf !== 1'b0 || evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop: got ovf=%b valid=%b, expected 0 1", ovf, evt_valid);
        end
        pop_cnt = 0;
        drain();
        n_vec++;
        if (pop_cnt != 4) begin
            n_err++;
            $display("FAIL full_pop count: got %0d pops, expected 4", pop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        inject(4'h2);
        exp_q.push_back(4'h2);
        repeat (8) cycle();
        n_vec++;
        if (evt_valid !== 1'b1 || evt_data !== 4'h2) begin
            n_err++;
            $display("FAIL reset_mid pre: got valid=%b data=%h, expected 1 2", evt_valid, evt_data);
        end
        inject(4'h4);
        wait_clr();
        reset_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        exp_q.delete();
        repeat (3) cycle();
        reset_n = 1'b1;
        rd_cnt = 0; clr_cnt = 0; any_valid = 1'b0;
        repeat (24) cycle();
        n_vec++;
        if (any_valid !== 1'b0 || clr_cnt != 0 || rd_cnt == 0) begin
            n_err++;
            $display("FAIL reset_mid post: got valid=%b clr=%0d rd=%0d, expected 0 0 nonzero",
                     any_valid, clr_cnt, rd_cnt);
        end
    endtask

    task automatic test_irq();
        logic prev, exp_irq, rose;
        inject(4'h1);
        exp_q.push_back(4'h1);
        prev = evt_valid;
        rose = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
`ifdef KEY_POLL_CTRL_IRQ_EN
            exp_irq = prev;
`else
            exp_irq = 1'b0;
`endif
            if (irq === 1'b1) rose = 1'b1;
            n_vec++;
            if (irq !== exp_irq) begin
                n_err++;
                $display("FAIL irq cycle %0d: got irq=%b, expected %b", i, irq, exp_irq);
            end
            prev = evt_valid;
        end
`ifdef KEY_POLL_CTRL_IRQ_EN
        n_vec++;
        if (rose !== 1'b1) begin
            n_err++;
            $display("FAIL irq rise: got irq never high, expected a rise");
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_no_activity();
        test_single_key();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
